// File: rtl/bk_multiword_adder.sv
// bk_multiword_adder: sequential WORDS x 16-bit adder. A single combinational 16-bit
// Brent-Kung slice is reused once per cycle. Each slice's carry-out is registered and
// becomes the carry-in of the next slice.
//
// Optional feature macro: BKW_OVERFLOW_EN. When it is defined, the signed-overflow
// output ovf is present.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   a, b, cin            W-bit operands and carry-in, sampled on the accept cycle
//   out_valid/out_ready  result handshake; out_valid is high only in DONE
//   sum, cout            registered result, {cout, sum} = a + b + cin
//   busy                 high in RUN or DONE
//   ovf                  signed overflow (BKW_OVERFLOW_EN only)
module bk_multiword_adder #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  busy
`ifdef BKW_OVERFLOW_EN
    ,
    output logic                  ovf
`endif
);

    localparam int unsigned W    = 16 * WORDS;
    localparam int unsigned IdxW = $clog2(WORDS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
`ifdef BKW_OVERFLOW_EN
    logic            ovf_q, ovf_d;
`endif

    // Slice operands selected by the current index; {idx, 4'b0} is 16*idx.
    logic [15:0] sl_a, sl_b, sl_sum;
    logic        sl_cout;
    logic        last;

    assign sl_a = a_q[{idx_q, 4'b0000} +: 16];
    assign sl_b = b_q[{idx_q, 4'b0000} +: 16];
    assign last = (idx_q == IdxW'(WORDS - 1));

    // 16-bit Brent-Kung slice. The carry-in is folded into bit 0's generate, so every
    // prefix generate gg[i] is the carry out of bit i.
    logic [15:0] bk_p, gg, gp;

    always_comb begin
        bk_p  = sl_a ^ sl_b;
        gg    = sl_a & sl_b;
        gg[0] = gg[0] | (bk_p[0] & carry_q);
        gp    = bk_p;
        // Up-sweep: build power-of-two group terms.
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
                gg[i] = gg[i] | (gp[i] & gg[i-d]);
                gp[i] = gp[i] & gp[i-d];
            end
        end
        // Down-sweep: fill in the remaining prefixes.
        for (int d = 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
                gg[i] = gg[i] | (gp[i] & gg[i-d]);
            end
        end
        sl_sum  = bk_p ^ {gg[14:0], carry_q};
        sl_cout = gg[15];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef BKW_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[{idx_q, 4'b0000} +: 16] = sl_sum;
                carry_d = sl_cout;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    cout_d  = sl_cout;
`ifdef BKW_OVERFLOW_EN
                    // Carry into the MSB xor carry out of the MSB.
                    ovf_d   = a_q[W-1] ^ b_q[W-1] ^ sl_sum[15] ^ sl_cout;
`endif
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef BKW_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef BKW_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake outputs decode the state register only.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef BKW_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bk_multiword_adder.sv
// Self-checking bench for bk_multiword_adder (WORDS = 4). An arithmetic reference
// model tracks accept/latency/handshake and compares every cycle, and directed vectors
// pin literal results.
module tb_bk_multiword_adder;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef BKW_OVERFLOW_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bk_multiword_adder #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef BKW_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 computing, 2 result pending
    int           m_phase = 0;
    int           m_cnt   = 0;
    logic [W:0]   m_res   = '0;
    logic [W:0]   m_pend  = '0;
    logic         m_ovf   = 1'b0;
    logic         m_ovf_p = 1'b0;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        logic [W-1:0] low;
        logic [W:0]   full;
        low  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, c};
        full = ref_add(x, y, c);
        return low[W-1] ^ full[W];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_res   = '0;
            m_ovf   = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  = ref_add(a, b, cin);
                    m_ovf_p = ref_ovf(a, b, cin);
                    m_cnt   = WORDS;
                    m_phase = 1;
                end
                1: begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_res   = m_pend;
                        m_ovf   = m_ovf_p;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Observed DUT accepts, for spacing checks.
    int  dut_acc   = 0;
    time dut_acc_t = 0;
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            dut_acc++;
            dut_acc_t = $time;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase != 1) begin
                chk("result", {cout, sum}, m_res);
`ifdef BKW_OVERFLOW_EN
                chk("ovf", ovf, m_ovf);
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic [W-1:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf, input int hold);
        int lat;
        chk("op_start_in_ready", in_ready, 1'b1);
        a = x;
        b = y;
        cin = c;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        // Later operand changes must not matter.
        a = ~x;
        b = ~y;
        cin = ~c;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, WORDS);
        chk("sum", sum, exp_sum);
        chk("cout", cout, exp_cout);
`ifdef BKW_OVERFLOW_EN
        chk("ovf_lit", ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) chk("ovf_arg", exp_ovf, 1'b0);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_result", {cout, sum}, {exp_cout, exp_sum});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 1'b0);
        chk("post_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  waited;
        int  acc0;
        time prev_t;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", {cout, sum}, '0);
`ifdef BKW_OVERFLOW_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full-width carry ripple, then slice-boundary carry, then mixed pattern.
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 0);
        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 0);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
              64'h2222_2222_2222_2211, 1'b0, 1'b0, 0);
        // Backpressure with ignored in_valid pulses.
        do_op(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1,
              64'h6666_8888_AAAA_CCCD, 1'b0, 1'b0, 6);
        // Signed overflow cases.
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 0);
        do_op(64'h5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'h2, 1'b1, 1'b0, 0);

        // Reset while slice index 2 is running.
        a = 64'h1111_1111_1111_1111;
        b = 64'h2222_2222_2222_2222;
        cin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_result", {cout, sum}, '0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_valid", out_valid, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        do_op(64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0, 0);

        // Back-to-back: in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_t    = 0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin a = 64'h1;                   b = 64'h2;                   cin = 1'b0; end
                1: begin a = 64'hFFFF;                b = 64'h1;                   cin = 1'b0; end
                2: begin a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000; cin = 1'b1; end
                default: begin a = 64'hDEAD_BEEF;     b = 64'h1234_0000_0000;      cin = 1'b1; end
            endcase
            acc0   = dut_acc;
            waited = 0;
            while (dut_acc == acc0 && waited < 20) begin
                tick();
                waited++;
            end
            chk("b2b_accept", dut_acc - acc0, 1);
            if (i > 0) chk("b2b_interval", dut_acc_t - prev_t, (WORDS + 2) * 10);
            prev_t = dut_acc_t;
        end
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk("b2b_last_result", {cout, sum}, {1'b0, 64'h0000_1234_DEAD_BEF0});
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bk_multiword_adder.md
# bk_multiword_adder

Sequential multi-word adder that splits a WORDS×16-bit addition into 16-bit slices. It feeds one slice per cycle through a single instance of the team's combinational 16-bit Brent-Kung adder slice and registers each slice's carry-out as the next slice's carry-in. It sits directly upstream of that slice, acting as its operand sequencer and result collector. Operands arrive and results leave through valid/ready handshakes.

## Interface
- WORDS, 4, number of 16-bit slices; total operand width W = 16*WORDS; legal range 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a  input  W  operand A, unsigned/two's-complement
- b  input  W  operand B
- cin  input  1  carry into slice 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  W  registered result
- cout  output  1  carry out of slice WORDS-1
- busy  output  1  high in RUN or DONE
- ovf  output  1  signed overflow; present only with BKW_OVERFLOW_EN

## Operation
- Reset is asynchronous and active-low. While rst_n = 0, all registers clear:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0; sum = 0; cout = 0; ovf = 0
  - internal slice index = 0; carry register = 0; operand registers = 0
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a, b and cin into internal registers, set index = 0 and carry = cin, then go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, drive the slice with a_reg[16k+:16], b_reg[16k+:16] and the carry register, where k = index.
  - Write the slice sum into sum[16k+:16] and the slice carry-out into the carry register, then increment index.
  - When k = WORDS-1, copy the slice carry-out into cout as well and go to DONE.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable.
  - On out_ready = 1, clear out_valid and go to IDLE.
  - Operands are never accepted in DONE, even when out_ready = 1 in the same cycle.
- sum is rewritten slice by slice during RUN and is meaningful only while out_valid = 1. After the output handshake it holds the last result until the next RUN overwrites it.
- Inputs a, b and cin are sampled only on the accept cycle; later changes have no effect.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(W+1). No saturation.
- A reset asserted mid-RUN or in DONE aborts the operation immediately. No partial result is flagged or preserved.

## Timing
- Accept on rising edge T0. Slices 0..WORDS-1 are computed in cycles T0+1..T0+WORDS.
- out_valid rises after edge T0+WORDS, giving a latency of WORDS cycles from accept to out_valid.
- The earliest next accept is on the edge after the output handshake. Throughput is at most one operation per WORDS+2 cycles.
- Critical path per cycle is one 16-bit Brent-Kung slice plus the carry register setup. There is no combinational path from in_valid or out_ready to any output except through state registers; in_ready and out_valid are decoded from the state register only.

## Configuration
- BKW_OVERFLOW_EN defined:
  - Port ovf is present.
  - It is updated in the last RUN cycle as ovf = a_reg[W-1] ^ b_reg[W-1] ^ sum_top[15] ^ slice_cout, i.e. the carry into the MSB xor the carry out.
  - It is held with sum, and is 0 on reset.
- BKW_OVERFLOW_EN undefined:
  - Port ovf and its register are absent.
  - All other behaviour is identical.

## Test plan
- WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → out_valid 4 cycles after accept; sum=0, cout=1 (carry ripples across all slices).
- a=0x0000_0000_0000_FFFF, b=0x1, cin=0 → sum=0x0000_0000_0001_0000, cout=0. Then a=0x1234_5678_9ABC_DEF0, b=0x0FED_CBA9_8765_4321 → sum=0x2222_2222_2222_2211, cout=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid → out_valid, sum and cout stay stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 → IDLE next cycle, in_ready=1.
- Assert rst_n=0 while index=2 of a running operation → all outputs read their reset values immediately, with no out_valid pulse. After release, a new operation 0x1+0x1 gives sum=0x2.
- With BKW_OVERFLOW_EN: a=0x7FFF_FFFF_FFFF_FFFF, b=1 → ovf=1, cout=0. Then a=b=0x8000_0000_0000_0000 → sum=0, ovf=1, cout=1. Then a=5, b=0xFFFF_FFFF_FFFF_FFFD → sum=2, ovf=0, cout=1.
- Back-to-back: hold in_valid=1 with out_ready=1 throughout → accepts occur exactly every WORDS+2 cycles, with no accept in DONE and the results in order.
